pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
Parameters:
- REQ-001: The block SHALL have parameter WIDTH, default 4, setting the PC and address width in bits (WIDTH >= 2).
- REQ-002: The block SHALL have parameter STACK_DEPTH, default 4, setting the number of return-address stack entries (STACK_DEPTH >= 1).
- REQ-003: The block SHALL have parameter RESET_ADDR, default 0, giving the WIDTH-bit PC value loaded on reset.

Ports (name, direction, width, meaning):
- REQ-004: The block SHALL have the following ports.
  - clk, input, 1: the single clock; all state updates on its rising edge.
  - rst, input, 1: synchronous, active-high reset.
  - en, input, 1: advance enable.
  - PC_INIT, input, WIDTH: load value.
  - set_pc, input, 1: load PC_INIT.
  - JUMP_ADDR, input, WIDTH: jump/call target.
  - jump, input, 1: absolute jump.
  - call, input, 1: push return address and jump.
  - ret, input, 1: pop return address.
  - OFFSET, input, WIDTH: two's-complement branch offset.
  - branch, input, 1: relative branch.
  - halt, input, 1: enter HALTED.
  - PC_CURR, output, WIDTH: registered current PC.
  - halted, output, 1: registered; 1 in HALTED.
  - stack_empty, output, 1: derived from the registered stack pointer.
  - stack_full, output, 1: derived from the registered stack pointer.
  - err, output, 1: registered, sticky stack overflow/underflow flag.

Function
- REQ-005: All state SHALL update only on the rising edge of clk; there SHALL be no combinational path from any input to any output.
- REQ-006: The block SHALL have a two-state FSM.
  - RUN -> HALTED on halt when en=1 and no higher-priority event occurs.
  - HALTED -> RUN only on set_pc or rst.
- REQ-007: The per-edge priority SHALL be rst > set_pc > (en=0 or HALTED: hold) > halt > ret > call > jump > branch > increment; exactly one action occurs per edge.
- REQ-008: On set_pc=1 the block SHALL load PC_CURR<=PC_INIT and state<=RUN, regardless of en or halted, leaving the stack and err unchanged.
- REQ-009: When en=0 (and no rst or set_pc), or when in HALTED, the block SHALL hold all state unchanged.
- REQ-010: On halt the block SHALL hold PC_CURR and set halted=1 on that edge.
- REQ-011: On ret with a non-empty stack the block SHALL set PC_CURR<=top entry and decrement the stack pointer.
- REQ-012: On ret with an empty stack the block SHALL hold PC_CURR, leave the stack unchanged and set err=1.
- REQ-013: On call with a non-full stack the block SHALL push (PC_CURR+1) mod 2^WIDTH and set PC_CURR<=JUMP_ADDR.
- REQ-014: On call with a full stack the block SHALL hold PC_CURR, push nothing and set err=1.
- REQ-015: On jump the block SHALL set PC_CURR<=JUMP_ADDR.
- REQ-016: On branch the block SHALL set PC_CURR<=(PC_CURR+sign-extended OFFSET) mod 2^WIDTH; overflow wraps silently.
- REQ-017: When no event is asserted the block SHALL set PC_CURR<=(PC_CURR+1) mod 2^WIDTH, so 2^WIDTH-1 wraps to 0.
- REQ-018: The block SHALL drive stack_empty=1 exactly when the stack holds 0 entries and stack_full=1 exactly when it holds STACK_DEPTH entries; for STACK_DEPTH=1 these are mutually exclusive.
- REQ-019: Once set, err SHALL remain 1 until rst; set_pc SHALL NOT clear it.
- REQ-020: When call and ret are asserted together, ret SHALL win and call SHALL be ignored, with no push.

Reset
- REQ-021: On an edge with rst=1 the block SHALL set PC_CURR=RESET_ADDR, stack pointer=0 (stack_empty=1, stack_full=0), halted=0, err=0 and state=RUN, overriding all other inputs.
- REQ-022: Stack entry contents after reset are don't-care and SHALL NOT be observable, because pops from an empty stack are blocked.
- REQ-023: A rst asserted mid-operation (HALTED, stack partially filled) SHALL restore the full reset state on the next edge.

Verification (WIDTH=4, STACK_DEPTH=2, RESET_ADDR=0)
- REQ-024: The bench SHALL check reset and wrap: rst one edge, then en=1 for 17 edges -> PC_CURR 0,1,...,15,0,1; halted=0, err=0.
- REQ-025: The bench SHALL check load and branch: set_pc with PC_INIT=4'hE, then branch with OFFSET=4'h3 -> PC_CURR=E then 1; then OFFSET=4'hE (-2) -> F.
- REQ-026: The bench SHALL check call/return nesting.
  - From PC=2: call to 8 -> PC=8, stack=[3].
  - call to C -> PC=C, stack_full=1.
  - ret -> PC=9; ret -> PC=3, stack_empty=1.
- REQ-027: The bench SHALL check overflow and underflow.
  - Third call with a full stack -> PC holds, err=1.
  - ret with an empty stack after rst -> PC holds, err=1, and err persists through set_pc.
- REQ-028: The bench SHALL check halt: halt at PC=5 -> PC stays 5 for 3 edges with jump asserted; set_pc with PC_INIT=0 -> PC=0, halted=0.
- REQ-029: The bench SHALL check priority: set_pc, jump and call asserted together with en=0 -> PC=PC_INIT, no push; call and ret together with stack=[3] -> PC=3, no push.

Source files
------------

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - control and status bundle between a sequencer and its driver
interface pc_seq_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] PC_INIT;
  logic             set_pc;
  logic [WIDTH-1:0] JUMP_ADDR;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] OFFSET;
  logic             branch;
  logic             halt;
  logic [WIDTH-1:0] PC_CURR;
  logic             halted;
  logic             stack_empty;
  logic             stack_full;
  logic             err;

  modport master (
    output en, PC_INIT, set_pc, JUMP_ADDR, jump, call, ret, OFFSET, branch, halt,
    input  PC_CURR, halted, stack_empty, stack_full, err
  );

  modport slave (
    input  en, PC_INIT, set_pc, JUMP_ADDR, jump, call, ret, OFFSET, branch, halt,
    output PC_CURR, halted, stack_empty, stack_full, err
  );
endinterface

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer with return-address stack and halt state
module pc_seq #(
  parameter int               WIDTH       = 4,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic     clk,
  input  logic     rst,
  pc_seq_if.slave  bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [WIDTH-1:0] r_pc;
  logic [SP_W-1:0]  r_sp;
  logic [0:0]       r_state;
  logic             r_err;
  logic [WIDTH-1:0] r_stack [STACK_DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_active;
  logic             w_do_ret;
  logic             w_do_call;
  logic             w_push;
  logic [WIDTH-1:0] w_pc_inc;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_top_idx;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
  assign w_pc_inc  = r_pc + WIDTH'(1);
  assign w_wr_idx  = IDX_W'(r_sp);
  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));

  // An edge is "active" only when nothing above halt in the priority order claims it.
  assign w_active  = !rst && !bus.set_pc && bus.en && (r_state == ST_RUN) && !bus.halt;
  // ret outranks call, so a simultaneous call is dropped without a push.
  assign w_do_ret  = w_active && bus.ret;
  assign w_do_call = w_active && !bus.ret && bus.call;
  assign w_push    = w_do_call && !w_full;

  // PC, stack pointer, FSM state and sticky error, in strict priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_ADDR;
      r_sp    <= '0;
      r_state <= ST_RUN;
      r_err   <= 1'b0;
    end else if (bus.set_pc) begin
      r_pc    <= bus.PC_INIT;
      r_state <= ST_RUN;
    end else if (!bus.en || (r_state == ST_HALTED)) begin
      r_pc    <= r_pc;
    end else if (bus.halt) begin
      r_state <= ST_HALTED;
    end else if (w_do_ret) begin
      if (w_empty) begin
        r_err <= 1'b1;
      end else begin
        r_pc <= r_stack[w_top_idx];
        r_sp <= r_sp - SP_W'(1);
      end
    end else if (w_do_call) begin
      if (w_full) begin
        r_err <= 1'b1;
      end else begin
        r_pc <= bus.JUMP_ADDR;
        r_sp <= r_sp + SP_W'(1);
      end
    end else if (bus.jump) begin
      r_pc <= bus.JUMP_ADDR;
    end else if (bus.branch) begin
      // Adding the raw WIDTH-bit offset equals adding its sign extension mod 2^WIDTH.
      r_pc <= r_pc + bus.OFFSET;
    end else begin
      r_pc <= w_pc_inc;
    end
  end

  // Stack storage carries no reset; stale entries are unreachable behind the pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_wr_idx] <= w_pc_inc;
    end
  end

  assign bus.PC_CURR     = r_pc;
  assign bus.halted      = (r_state == ST_HALTED);
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq against a queue-based model
module tb_pc_seq;
  localparam int W     = 4;
  localparam int DEPTH = 2;
  localparam int MODN  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pc_seq_if #(.WIDTH(W)) bus ();

  pc_seq #(.WIDTH(W), .STACK_DEPTH(DEPTH), .RESET_ADDR(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: PC as an integer, stack as a queue of return addresses.
  int m_pc    = 0;
  int m_stk[$];
  bit m_halt  = 1'b0;
  bit m_err   = 1'b0;
  bit m_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= MODN / 2) ? v - MODN : v;
  endfunction

  // Apply the sequencing rules to the model using the inputs seen at this edge.
  task automatic model_step();
    int off;
    if (rst) begin
      m_pc = 0; m_stk.delete(); m_halt = 1'b0; m_err = 1'b0;
    end else if (bus.set_pc) begin
      m_pc = int'(bus.PC_INIT); m_halt = 1'b0;
    end else if (!bus.en || m_halt) begin
      m_pc = m_pc;
    end else if (bus.halt) begin
      m_halt = 1'b1;
    end else if (bus.ret) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (bus.call) begin
      if (m_stk.size() >= DEPTH) m_err = 1'b1;
      else begin
        m_stk.push_back((m_pc + 1) % MODN);
        m_pc = int'(bus.JUMP_ADDR);
      end
    end else if (bus.jump) begin
      m_pc = int'(bus.JUMP_ADDR);
    end else if (bus.branch) begin
      off  = sx(int'(bus.OFFSET));
      m_pc = (((m_pc + off) % MODN) + MODN) % MODN;
    end else begin
      m_pc = (m_pc + 1) % MODN;
    end
    m_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.en = 1'b1; bus.set_pc = 1'b0; bus.jump = 1'b0; bus.call = 1'b0;
    bus.ret = 1'b0; bus.branch = 1'b0; bus.halt = 1'b0;
    bus.PC_INIT = '0; bus.JUMP_ADDR = '0; bus.OFFSET = '0;
  endtask

  // Compare every output with the model on each falling edge once reset has been applied.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_pc",     int'(bus.PC_CURR),     m_pc);
      check("cmp_halted", int'(bus.halted),      int'(m_halt));
      check("cmp_err",    int'(bus.err),         int'(m_err));
      check("cmp_empty",  int'(bus.stack_empty), int'(m_stk.size() == 0));
      check("cmp_full",   int'(bus.stack_full),  int'(m_stk.size() == DEPTH));
    end
  end

  initial begin
    idle();
    rst = 1'b1; bus.en = 1'b0;
    bus.jump = 1'b1; bus.call = 1'b1; bus.JUMP_ADDR = 4'h9;
    tick();
    check("rst_pc", int'(bus.PC_CURR), 0);
    check("rst_empty", int'(bus.stack_empty), 1);
    check("rst_full", int'(bus.stack_full), 0);
    check("rst_halted", int'(bus.halted), 0);
    check("rst_err", int'(bus.err), 0);

    // Free-running increment with wrap.
    idle();
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("wrap_pc", int'(bus.PC_CURR), k % 16);
    end
    check("wrap_halted", int'(bus.halted), 0);
    check("wrap_err", int'(bus.err), 0);

    // en low holds the PC.
    bus.en = 1'b0; tick(); tick();
    check("hold_en0", int'(bus.PC_CURR), 1);

    // Load then relative branches.
    idle(); bus.set_pc = 1'b1; bus.PC_INIT = 4'hE; tick();
    check("load_e", int'(bus.PC_CURR), 14);
    idle(); bus.branch = 1'b1; bus.OFFSET = 4'h3; tick();
    check("br_plus3", int'(bus.PC_CURR), 1);
    bus.OFFSET = 4'hE; tick();
    check("br_minus2", int'(bus.PC_CURR), 15);

    // Nested call and return.
    idle(); rst = 1'b1; tick();
    idle(); bus.set_pc = 1'b1; bus.PC_INIT = 4'h2; tick();
    idle(); bus.call = 1'b1; bus.JUMP_ADDR = 4'h8; tick();
    check("call1_pc", int'(bus.PC_CURR), 8);
    check("call1_empty", int'(bus.stack_empty), 0);
    bus.JUMP_ADDR = 4'hC; tick();
    check("call2_pc", int'(bus.PC_CURR), 12);
    check("call2_full", int'(bus.stack_full), 1);
    idle(); bus.ret = 1'b1; tick();
    check("ret1_pc", int'(bus.PC_CURR), 9);
    tick();
    check("ret2_pc", int'(bus.PC_CURR), 3);
    check("ret2_empty", int'(bus.stack_empty), 1);

    // Overflow: third call on a full stack.
    idle(); bus.call = 1'b1; bus.JUMP_ADDR = 4'h8; tick();
    bus.JUMP_ADDR = 4'hC; tick();
    bus.JUMP_ADDR = 4'h0; tick();
    check("ovf_pc", int'(bus.PC_CURR), 12);
    check("ovf_err", int'(bus.err), 1);
    check("ovf_full", int'(bus.stack_full), 1);

    // Underflow after reset, err survives set_pc.
    idle(); rst = 1'b1; tick();
    check("rst_clr_err", int'(bus.err), 0);
    idle(); bus.ret = 1'b1; tick();
    check("unf_pc", int'(bus.PC_CURR), 0);
    check("unf_err", int'(bus.err), 1);
    idle(); bus.set_pc = 1'b1; bus.PC_INIT = 4'h7; tick();
    check("unf_setpc_pc", int'(bus.PC_CURR), 7);
    check("unf_err_sticky", int'(bus.err), 1);

    // Halt freezes the PC until set_pc.
    idle(); rst = 1'b1; tick();
    idle(); bus.set_pc = 1'b1; bus.PC_INIT = 4'h5; tick();
    idle(); bus.halt = 1'b1; tick();
    check("halt_pc", int'(bus.PC_CURR), 5);
    check("halt_flag", int'(bus.halted), 1);
    idle(); bus.jump = 1'b1; bus.JUMP_ADDR = 4'hA;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halted_hold", int'(bus.PC_CURR), 5);
    end
    idle(); bus.set_pc = 1'b1; bus.PC_INIT = 4'h0; tick();
    check("unhalt_pc", int'(bus.PC_CURR), 0);
    check("unhalt_flag", int'(bus.halted), 0);

    // Priority: set_pc beats jump/call even with en low.
    idle(); bus.en = 1'b0; bus.set_pc = 1'b1; bus.PC_INIT = 4'h6;
    bus.jump = 1'b1; bus.call = 1'b1; bus.JUMP_ADDR = 4'hB; tick();
    check("prio_setpc_pc", int'(bus.PC_CURR), 6);
    check("prio_setpc_empty", int'(bus.stack_empty), 1);

    // Priority: ret beats call.
    idle(); bus.set_pc = 1'b1; bus.PC_INIT = 4'h2; tick();
    idle(); bus.call = 1'b1; bus.JUMP_ADDR = 4'h8; tick();
    idle(); bus.call = 1'b1; bus.ret = 1'b1; bus.JUMP_ADDR = 4'hD; tick();
    check("prio_ret_pc", int'(bus.PC_CURR), 3);
    check("prio_ret_empty", int'(bus.stack_empty), 1);
    check("prio_ret_err", int'(bus.err), 0);

    idle(); tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
